// File: rtl/jt51_dac_rx_pkg.sv
// Shared widths and the decoded DAC word layout for the YM2151 serial DAC receiver.
package jt51_dac_rx_pkg;

  localparam int MANT_W    = 10;
  localparam int EXP_W     = 3;
  localparam int WORD_W    = 13;
  localparam int SLOT_BITS = 16;
  localparam int OUT_W     = 16;

  // Serial word as it sits in the shift register: exponent in the top bits.
  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } dac_word_t;

endpackage

// File: rtl/jt51_dac_rx_fp2lin.sv
// Combinational YM3012-style float to signed linear conversion.
module jt51_dac_rx_fp2lin
  import jt51_dac_rx_pkg::*;
(
  input  dac_word_t                word,
  output logic signed [OUT_W-1:0]  lin
);

  logic signed [MANT_W-1:0] s;
  logic signed [OUT_W-1:0]  s_ext;

  // Offset-binary mantissa becomes two's complement by flipping its MSB.
  always_comb begin
    s     = {~word.mant[MANT_W-1], word.mant[MANT_W-2:0]};
    s_ext = {{(OUT_W-MANT_W){s[MANT_W-1]}}, s};
    lin   = '0;
    if (word.exp != '0) begin
      lin = s_ext <<< (word.exp - 1'b1);
    end
  end

endmodule

// File: rtl/jt51_dac_rx.sv
// Serial DAC stream receiver: shifts SO, latches left/right on SH1/SH2 falling edges.
// Optional framing-error checker enabled by defining JT51_DAC_RX_ERR_EN.
module jt51_dac_rx
  import jt51_dac_rx_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic                    so,
  input  logic                    sh1,
  input  logic                    sh2,
  output logic signed [OUT_W-1:0] left,
  output logic signed [OUT_W-1:0] right,
  output logic                    sample
`ifdef JT51_DAC_RX_ERR_EN
  ,
  output logic                    frame_err
`endif
);

  logic [WORD_W-1:0]       sr;
  logic                    sh1_d;
  logic                    sh2_d;
  logic                    fall1;
  logic                    fall2;
  dac_word_t               word;
  logic signed [OUT_W-1:0] lin;

  assign fall1 = cen & sh1_d & ~sh1;
  assign fall2 = cen & sh2_d & ~sh2;
  assign word  = dac_word_t'(sr);

  jt51_dac_rx_fp2lin u_fp2lin (
    .word (word),
    .lin  (lin)
  );

  // Decode sees sr before this cen's shift, so the strobe bit is not part of the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr     <= '0;
      sh1_d  <= 1'b1;
      sh2_d  <= 1'b1;
      left   <= '0;
      right  <= '0;
      sample <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cen) begin
        sr    <= {so, sr[WORD_W-1:1]};
        sh1_d <= sh1;
        sh2_d <= sh2;
        if (fall1) begin
          left <= lin;
        end
        if (fall2) begin
          right  <= lin;
          sample <= 1'b1;
        end
      end
    end
  end

`ifdef JT51_DAC_RX_ERR_EN
  localparam logic [4:0] CNT_MAX  = 5'd31;
  localparam logic [4:0] CNT_SLOT = 5'(SLOT_BITS);

  logic [4:0] bit_cnt;
  logic       armed;

  // The strobe cen already carries the first bit of the next slot, hence the reload of 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      armed     <= 1'b0;
      frame_err <= 1'b0;
    end else if (cen) begin
      if (fall1 | fall2) begin
        bit_cnt <= 5'd1;
        armed   <= 1'b1;
        if ((armed && (bit_cnt != CNT_SLOT)) || (fall1 && fall2)) begin
          frame_err <= 1'b1;
        end
      end else if (bit_cnt != CNT_MAX) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jt51_dac_rx.sv
// Directed self-checking bench for jt51_dac_rx; error checks build with JT51_DAC_RX_ERR_EN.
module tb_jt51_dac_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        so;
  logic        sh1;
  logic        sh2;
  logic [15:0] left;
  logic [15:0] right;
  logic        sample;
`ifdef JT51_DAC_RX_ERR_EN
  logic        frame_err;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          gap      = 1'b1;
  int          slot_pos = 0;
  logic [1:0]  pend     = 2'b00;
  logic [15:0] exp_left;
  logic [15:0] exp_right;

  jt51_dac_rx dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .so        (so),
    .sh1       (sh1),
    .sh2       (sh2),
    .left      (left),
    .right     (right),
    .sample    (sample)
`ifdef JT51_DAC_RX_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One serial bit; with gap set, cen is high for one clk out of two.
  task automatic cen_bit(input logic b, input logic s1, input logic s2);
    if (gap) begin
      @(posedge clk);
      #1;
    end
    so  = b;
    sh1 = s1;
    sh2 = s2;
    cen = 1'b1;
    @(posedge clk);
    #1;
    if (gap) cen = 1'b0;
  endtask

  // Pads then 13 data bits LSB first; a pending strobe falls on the slot's first bit.
  task automatic send_word(input logic [12:0] w, input logic [1:0] mask, input int nbits);
    for (int i = slot_pos; i < nbits; i++) begin
      logic b;
      b = (i < nbits - 13) ? 1'b0 : w[i - (nbits - 13)];
      cen_bit(b, ~(i == 0 && pend[0]), ~(i == 0 && pend[1]));
    end
    pend     = mask;
    slot_pos = 0;
  endtask

  task automatic flush();
    cen_bit(1'b0, ~pend[0], ~pend[1]);
    pend     = 2'b00;
    slot_pos = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b0; so = 1'b0; sh1 = 1'b1; sh2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (left !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_left: got %h expected %h", left, 16'h0000); end
    n_checks++; if (right !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_right: got %h expected %h", right, 16'h0000); end
    n_checks++; if (sample !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sample: got %b expected 0", sample); end
`ifdef JT51_DAC_RX_ERR_EN
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", frame_err); end
`endif
    rst = 1'b0;
    cen_bit(1'b0, 1'b1, 1'b0);
    slot_pos = 1;
    n_checks++; if (sample !== 1'b1) begin n_fail++; $display("[TB] FAIL held_low_sample: got %b expected 1", sample); end
    n_checks++; if (right !== 16'h0000) begin n_fail++; $display("[TB] FAIL held_low_right: got %h expected %h", right, 16'h0000); end
  endtask

  task automatic test_full_scale();
    send_word({3'd7, 10'h3FF}, 2'b01, 16);
    send_word({3'd7, 10'h3FF}, 2'b10, 16);
    flush();
    n_checks++; if (left !== 16'h7FC0) begin n_fail++; $display("[TB] FAIL full_left: got %h expected %h", left, 16'h7FC0); end
    n_checks++; if (right !== 16'h7FC0) begin n_fail++; $display("[TB] FAIL full_right: got %h expected %h", right, 16'h7FC0); end
    n_checks++; if (sample !== 1'b1) begin n_fail++; $display("[TB] FAIL full_sample_hi: got %b expected 1", sample); end
    @(posedge clk);
    #1;
    n_checks++; if (sample !== 1'b0) begin n_fail++; $display("[TB] FAIL full_sample_lo: got %b expected 0", sample); end
    exp_left  = 16'h7FC0;
    exp_right = 16'h7FC0;
  endtask

  task automatic test_decode_patterns();
    logic [12:0] words [8];
    logic [1:0]  masks [8];
    logic [15:0] vals  [8];
    words[0] = {3'd7, 10'h000}; masks[0] = 2'b01; vals[0] = 16'h8000;
    words[1] = {3'd5, 10'h200}; masks[1] = 2'b10; vals[1] = 16'h0000;
    words[2] = {3'd1, 10'h201}; masks[2] = 2'b01; vals[2] = 16'h0001;
    words[3] = {3'd3, 10'h1FF}; masks[3] = 2'b10; vals[3] = 16'hFFFC;
    words[4] = {3'd0, 10'h2AB}; masks[4] = 2'b01; vals[4] = 16'h0000;
    words[5] = {3'd0, 10'h3FF}; masks[5] = 2'b10; vals[5] = 16'h0000;
    words[6] = {3'd4, 10'h155}; masks[6] = 2'b01; vals[6] = 16'hFAA8;
    words[7] = {3'd2, 10'h2F0}; masks[7] = 2'b10; vals[7] = 16'h01E0;
    for (int k = 0; k < 8; k++) begin
      send_word(words[k], masks[k], 16);
      flush();
      if (masks[k][0]) exp_left = vals[k];
      if (masks[k][1]) exp_right = vals[k];
      n_checks++; if (left !== exp_left) begin n_fail++; $display("[TB] FAIL decode%0d_left: got %h expected %h", k, left, exp_left); end
      n_checks++; if (right !== exp_right) begin n_fail++; $display("[TB] FAIL decode%0d_right: got %h expected %h", k, right, exp_right); end
      n_checks++; if (sample !== masks[k][1]) begin n_fail++; $display("[TB] FAIL decode%0d_sample: got %b expected %b", k, sample, masks[k][1]); end
    end
  endtask

  task automatic test_back_to_back();
    gap = 1'b0;
    send_word({3'd7, 10'h3FF}, 2'b10, 16);
    flush();
    n_checks++; if (right !== 16'h7FC0) begin n_fail++; $display("[TB] FAIL b2b_right: got %h expected %h", right, 16'h7FC0); end
    n_checks++; if (sample !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_sample_hi: got %b expected 1", sample); end
    @(posedge clk);
    #1;
    n_checks++; if (sample !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_sample_lo: got %b expected 0", sample); end
    cen = 1'b0;
    gap = 1'b1;
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 7; i++) cen_bit(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (left !== 16'h0000) begin n_fail++; $display("[TB] FAIL midrst_left: got %h expected %h", left, 16'h0000); end
    n_checks++; if (right !== 16'h0000) begin n_fail++; $display("[TB] FAIL midrst_right: got %h expected %h", right, 16'h0000); end
    n_checks++; if (sample !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_sample: got %b expected 0", sample); end
    rst = 1'b0; sh1 = 1'b1; sh2 = 1'b1;
    slot_pos = 0; pend = 2'b00;
    send_word({3'd6, 10'h2AA}, 2'b01, 16);
    send_word({3'd3, 10'h180}, 2'b10, 16);
    flush();
    n_checks++; if (left !== 16'h1540) begin n_fail++; $display("[TB] FAIL midrst_frame_left: got %h expected %h", left, 16'h1540); end
    n_checks++; if (right !== 16'hFE00) begin n_fail++; $display("[TB] FAIL midrst_frame_right: got %h expected %h", right, 16'hFE00); end
    n_checks++; if (sample !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_frame_sample: got %b expected 1", sample); end
`ifdef JT51_DAC_RX_ERR_EN
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_err: got %b expected 0", frame_err); end
`endif
  endtask

`ifdef JT51_DAC_RX_ERR_EN
  task automatic test_frame_err();
    send_word({3'd7, 10'h3FF}, 2'b01, 16);
    send_word({3'd7, 10'h000}, 2'b10, 15);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_before_short: got %b expected 0", frame_err); end
    flush();
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_short_slot: got %b expected 1", frame_err); end
    n_checks++; if (right !== 16'h8000) begin n_fail++; $display("[TB] FAIL err_short_right: got %h expected %h", right, 16'h8000); end
    send_word({3'd1, 10'h201}, 2'b01, 16);
    flush();
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b expected 1", frame_err); end
    n_checks++; if (left !== 16'h0001) begin n_fail++; $display("[TB] FAIL err_sticky_left: got %h expected %h", left, 16'h0001); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_cleared: got %b expected 0", frame_err); end
    rst = 1'b0; sh1 = 1'b1; sh2 = 1'b1;
    slot_pos = 0; pend = 2'b00;
  endtask

  task automatic test_simultaneous();
    send_word({3'd7, 10'h3FF}, 2'b01, 16);
    send_word({3'd1, 10'h201}, 2'b11, 16);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL simul_pre_err: got %b expected 0", frame_err); end
    n_checks++; if (left !== 16'h7FC0) begin n_fail++; $display("[TB] FAIL simul_pre_left: got %h expected %h", left, 16'h7FC0); end
    flush();
    n_checks++; if (left !== 16'h0001) begin n_fail++; $display("[TB] FAIL simul_left: got %h expected %h", left, 16'h0001); end
    n_checks++; if (right !== 16'h0001) begin n_fail++; $display("[TB] FAIL simul_right: got %h expected %h", right, 16'h0001); end
    n_checks++; if (sample !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_sample: got %b expected 1", sample); end
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_err: got %b expected 1", frame_err); end
  endtask
`endif

  initial begin
    $display("[TB] starting jt51_dac_rx bench");
    test_reset();
    test_full_scale();
    test_decode_patterns();
    test_back_to_back();
    test_reset_mid_word();
`ifdef JT51_DAC_RX_ERR_EN
    test_frame_err();
    test_simultaneous();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
